// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   word_t      : 32-bit bus word, reused for addresses and data
//   ramstate_t  : status reported by the single-ported RAM
//   arb_state_t : arbiter FSM state
//   ARB_I/ARB_D : encoding of the last-granted side
package memory_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISERV = 2'd1,
        DSERV = 2'd2,
        FAULT = 2'd3
    } arb_state_t;

    localparam logic ARB_I = 1'b0;
    localparam logic ARB_D = 1'b1;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of fetch-port, data-port and RAM-side signals for memory_arbiter.
//   modport arb : arbiter view (requests and RAM status in, waits/loads/RAM controls out)
//   modport tb  : environment view (CPU datapath and RAM model together)
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    logic      err;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/memory_arbiter_timeout.sv
// Service watchdog counter for memory_arbiter.
//   CLK      : clock, rising edge
//   RST      : synchronous reset, active-high
//   clr_i    : force count to zero (held while no transaction is granted)
//   en_i     : count one service cycle
//   expire_o : count has reached TIMEOUT-1
module memory_arbiter_timeout #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the single-ported RAM between the instruction-fetch port and
// the data port. One side is granted at a time; the granted transaction is
// latched and held on the RAM bus until ACCESS, an abort, or a fault.
//   CLK  : clock, rising edge
//   RST  : synchronous reset, active-high
//   bus  : memory_arbiter_if.arb (fetch port, data port, RAM port, err)
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no transaction granted, RAM controls at zero
//   ISERV | fetch granted, latched read on the RAM bus
//   DSERV | data access granted, latched read/write on bus
//   FAULT | RAM error or watchdog expiry; err held, only RST exits
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          CLK,
    input  logic          RST,
    memory_arbiter_if.arb bus
);

    arb_state_t state_q;
    logic       lastgnt_q;
    word_t      addr_q;
    word_t      store_q;
    logic       ren_q;
    logic       wen_q;
    logic       err_q;

    logic dreq;
    logic access;
    logic in_serv;
    logic gnt_i;
    logic gnt_d;
    logic done;
    logic abort;
    logic fault;
    logic expire;

    memory_arbiter_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .CLK      (CLK),
        .RST      (RST),
        .clr_i    (state_q == IDLE),
        .en_i     (in_serv),
        .expire_o (expire)
    );

    always_comb begin
        dreq    = bus.dREN | bus.dWEN;
        access  = (bus.ramstate == ACCESS);
        in_serv = (state_q == ISERV) || (state_q == DSERV);

        // Under contention the side that did not win last time gets the grant.
        gnt_d = dreq & (~bus.iREN | (lastgnt_q == ARB_I));
        gnt_i = bus.iREN & (~dreq | (lastgnt_q == ARB_D));

        // Completion beats everything; writes (wen_q) are never aborted.
        done  = in_serv & access;
        abort = in_serv & ~access &
                (((state_q == ISERV) & ~bus.iREN) |
                 ((state_q == DSERV) & ~wen_q & ~bus.dREN));
        fault = in_serv & ~access & ~abort &
                ((bus.ramstate == ERROR) | expire);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            lastgnt_q <= ARB_I;
            addr_q    <= '0;
            store_q   <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_d) begin
                        state_q   <= DSERV;
                        lastgnt_q <= ARB_D;
                        addr_q    <= bus.daddr;
                        store_q   <= bus.dWEN ? bus.dstore : '0;
                        ren_q     <= bus.dREN;
                        wen_q     <= bus.dWEN;
                    end else if (gnt_i) begin
                        state_q   <= ISERV;
                        lastgnt_q <= ARB_I;
                        addr_q    <= bus.iaddr;
                        store_q   <= '0;
                        ren_q     <= 1'b1;
                        wen_q     <= 1'b0;
                    end
                end
                ISERV, DSERV: begin
                    if (done || abort || fault) begin
                        state_q <= fault ? FAULT : IDLE;
                        err_q   <= fault;
                        addr_q  <= '0;
                        store_q <= '0;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                    end
                end
                FAULT: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ramREN   = ren_q;
    assign bus.ramWEN   = wen_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.err      = err_q;

    assign bus.iwait = bus.iREN & ~((state_q == ISERV) & access);
    assign bus.dwait = dreq & ~((state_q == DSERV) & access);
    assign bus.iload = (state_q == ISERV) ? bus.ramload : '0;
    assign bus.dload = (state_q == DSERV) ? bus.ramload : '0;

endmodule
